// File: rtl/bcd_pkg.sv
// Shared types and helpers for the multi-digit BCD scan decoder.
package bcd_pkg;

  typedef enum logic {IDLE, SCAN} state_t;

  localparam logic [3:0] BCD_MAX    = 4'd9;
  localparam int         DEC_W      = 10;
  localparam int         MAX_DIGITS = 16;
  localparam int         PAD_W      = 4 * MAX_DIGITS;

  // Digit i (i>=1) is blankable when it and every more significant digit are zero.
  function automatic logic [MAX_DIGITS-1:0] blankMask(input logic [PAD_W-1:0] word,
                                                      input int digits);
    logic                  allZero;
    logic [MAX_DIGITS-1:0] mask;
    allZero = 1'b1;
    mask    = '0;
    for (int i = MAX_DIGITS - 1; i >= 1; i--) begin
      if (i < digits) begin
        allZero = allZero && (word[4*i +: 4] == 4'd0);
        mask[i] = allZero;
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/bcd_onehot_dec.sv
// Single-nibble BCD to one-hot decimal decoder; codes above 9 give all-zero plus a flag.
module bcd_onehot_dec
  import bcd_pkg::*;
(
  input  logic [3:0]       nibble_i,
  output logic [DEC_W-1:0] onehot_o,
  output logic             invalid_o
);

  always_comb begin
    invalid_o = (nibble_i > BCD_MAX);
    onehot_o  = '0;
    if (!invalid_o) begin
      onehot_o = DEC_W'(1) << nibble_i;
    end
  end

endmodule

// File: rtl/bcd_scan_decoder.sv
// Latches a packed BCD word and scans its digits one at a time as one-hot decimal
// plus a one-hot digit select, with blanking, error flag and frame repeat.
module bcd_scan_decoder
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int DWELL  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_bcd,
  input  logic                  blank_lz,
  input  logic                  repeat_en,
  output logic [DEC_W-1:0]      dec_out,
  output logic [DIGITS-1:0]     dig_sel,
  output logic                  err,
  output logic                  frame_done
);

  localparam int IDX_W = $clog2(DIGITS);
  localparam int DW_W  = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);
  localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL - 1);

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DW_W-1:0]       dwell_q, dwell_d;
  logic [4*DIGITS-1:0]   word_q, word_d;
  logic                  blank_q, blank_d;
  logic                  err_q, err_d;

  logic                  lastCycle;
  logic                  accept;
  logic                  badAny;
  logic [3:0]            curNibble;
  logic [DIGITS-1:0]     selVec;
  logic [DIGITS-1:0]     blankVec;
  logic                  curBlank;
  logic [DEC_W-1:0]      decRaw;
  logic                  curInvalid;

  assign lastCycle = (state_q == SCAN) && (idx_q == IDX_LAST) && (dwell_q == DWELL_LAST);
  assign in_ready  = !rst && ((state_q == IDLE) || lastCycle);
  assign accept    = in_valid && in_ready;
  assign blankVec  = DIGITS'(blankMask(PAD_W'(word_q), DIGITS));
  assign curBlank  = blank_q && blankVec[idx_q];

  always_comb begin
    badAny    = 1'b0;
    curNibble = '0;
    selVec    = '0;
    for (int i = 0; i < DIGITS; i++) begin
      badAny    = badAny | (in_bcd[4*i +: 4] > BCD_MAX);
      selVec[i] = (idx_q == IDX_W'(i));
      if (idx_q == IDX_W'(i)) begin
        curNibble = word_q[4*i +: 4];
      end
    end
  end

  bcd_onehot_dec u_dec (
    .nibble_i  (curNibble),
    .onehot_o  (decRaw),
    .invalid_o (curInvalid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      dwell_q <= '0;
      word_q  <= '0;
      blank_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dwell_q <= dwell_d;
      word_q  <= word_d;
      blank_q <= blank_d;
      err_q   <= err_d;
    end
  end

  // An accept always wins, so a word offered on the last cycle starts a frame with no gap.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dwell_d = dwell_q;
    word_d  = word_q;
    blank_d = blank_q;
    err_d   = err_q;
    if (accept) begin
      word_d  = in_bcd;
      blank_d = blank_lz;
      err_d   = badAny;
      idx_d   = '0;
      dwell_d = '0;
      state_d = SCAN;
    end else if (state_q == SCAN) begin
      if (dwell_q == DWELL_LAST) begin
        dwell_d = '0;
        if (idx_q == IDX_LAST) begin
          idx_d = '0;
          if (!repeat_en) begin
            state_d = IDLE;
          end
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end else begin
        dwell_d = dwell_q + DW_W'(1);
      end
    end
  end

  always_comb begin
    dig_sel    = '0;
    dec_out    = '0;
    err        = err_q;
    frame_done = lastCycle;
    if (state_q == SCAN) begin
      dig_sel = selVec;
      dec_out = (curBlank || curInvalid) ? '0 : decRaw;
    end
  end

endmodule

// File: tb/tb_bcd_scan_decoder.sv
// Directed self-checking bench for bcd_scan_decoder with DIGITS=4, DWELL=2.
module tb_bcd_scan_decoder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_bcd;
  logic        blank_lz;
  logic        repeat_en;
  logic [9:0]  dec_out;
  logic [3:0]  dig_sel;
  logic        err;
  logic        frame_done;

  int testCount = 0;
  int failCount = 0;

  bcd_scan_decoder #(.DIGITS(4), .DWELL(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_bcd     (in_bcd),
    .blank_lz   (blank_lz),
    .repeat_en  (repeat_en),
    .dec_out    (dec_out),
    .dig_sel    (dig_sel),
    .err        (err),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Offers a word from IDLE (or a last cycle) and returns at the first cycle of the frame.
  task automatic applyStimulus(input logic [15:0] bcd, input logic blz, input logic rep, input logic holdValid);
    in_valid  = 1'b1;
    in_bcd    = bcd;
    blank_lz  = blz;
    repeat_en = rep;
    checkOutput("accept_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    if (!holdValid) in_valid = 1'b0;
  endtask

  // Checks all 8 cycles of a frame starting at its first cycle; optionally changes inputs mid-frame.
  task automatic scanFrame(input string tag, input logic [9:0] e0, input logic [9:0] e1,
                           input logic [9:0] e2, input logic [9:0] e3,
                           input int chgCycle, input logic chgValid, input logic [15:0] chgBcd,
                           input logic pulse);
    logic [9:0] expDec [4];
    expDec[0] = e0; expDec[1] = e1; expDec[2] = e2; expDec[3] = e3;
    for (int c = 0; c < 8; c++) begin
      checkOutput({tag, "_sel"},   32'(dig_sel),    32'(4'b0001 << (c / 2)));
      checkOutput({tag, "_dec"},   32'(dec_out),    32'(expDec[c / 2]));
      checkOutput({tag, "_done"},  32'(frame_done), 32'(c == 7));
      checkOutput({tag, "_ready"}, 32'(in_ready),   32'(c == 7));
      if (c == chgCycle) begin
        in_valid = chgValid;
        in_bcd   = chgBcd;
      end
      if (pulse && c == chgCycle + 1) in_valid = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_sel"},   32'(dig_sel),    32'd0);
    checkOutput({tag, "_dec"},   32'(dec_out),    32'd0);
    checkOutput({tag, "_ready"}, 32'(in_ready),   32'd1);
    checkOutput({tag, "_done"},  32'(frame_done), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_bcd    = 16'h0;
    blank_lz  = 1'b0;
    repeat_en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ready", 32'(in_ready),   32'd0);
    checkOutput("rst_sel",   32'(dig_sel),    32'd0);
    checkOutput("rst_dec",   32'(dec_out),    32'd0);
    checkOutput("rst_err",   32'(err),        32'd0);
    checkOutput("rst_done",  32'(frame_done), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    // Basic frame
    applyStimulus(16'h1234, 1'b0, 1'b0, 1'b0);
    checkOutput("basic_err", 32'(err), 32'd0);
    scanFrame("basic", 10'h010, 10'h008, 10'h004, 10'h002, -1, 1'b0, 16'h0, 1'b0);
    checkIdle("basic_idle");

    // Blanking on and off
    applyStimulus(16'h0070, 1'b1, 1'b0, 1'b0);
    scanFrame("blank_on", 10'h001, 10'h080, 10'h000, 10'h000, -1, 1'b0, 16'h0, 1'b0);
    applyStimulus(16'h0070, 1'b0, 1'b0, 1'b0);
    scanFrame("blank_off", 10'h001, 10'h080, 10'h001, 10'h001, -1, 1'b0, 16'h0, 1'b0);

    // Invalid code flags err and holds it until the next accept
    applyStimulus(16'h12A4, 1'b0, 1'b0, 1'b0);
    checkOutput("inv_err", 32'(err), 32'd1);
    scanFrame("inv", 10'h010, 10'h000, 10'h004, 10'h002, -1, 1'b0, 16'h0, 1'b0);
    checkOutput("inv_err_hold", 32'(err), 32'd1);
    applyStimulus(16'h0000, 1'b0, 1'b0, 1'b0);
    checkOutput("clr_err", 32'(err), 32'd0);
    scanFrame("zero", 10'h001, 10'h001, 10'h001, 10'h001, -1, 1'b0, 16'h0, 1'b0);

    // Back-to-back: next word presented on the last cycle, no idle gap
    applyStimulus(16'h1111, 1'b0, 1'b0, 1'b1);
    scanFrame("b2b_a", 10'h002, 10'h002, 10'h002, 10'h002, 7, 1'b1, 16'h2222, 1'b0);
    in_valid = 1'b0;
    scanFrame("b2b_b", 10'h004, 10'h004, 10'h004, 10'h004, -1, 1'b0, 16'h0, 1'b0);
    checkIdle("b2b_idle");

    // Repeat with an ignored mid-frame offer
    applyStimulus(16'h5678, 1'b0, 1'b1, 1'b0);
    scanFrame("rep1", 10'h100, 10'h080, 10'h040, 10'h020, 3, 1'b1, 16'h9999, 1'b1);
    repeat_en = 1'b0;
    scanFrame("rep2", 10'h100, 10'h080, 10'h040, 10'h020, -1, 1'b0, 16'h0, 1'b0);
    checkOutput("rep_err", 32'(err), 32'd0);
    checkIdle("rep_idle");

    // Reset while digit 2 is shown
    applyStimulus(16'h0A00, 1'b0, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    checkOutput("mid_sel", 32'(dig_sel), 32'b0100);
    checkOutput("mid_err", 32'(err),     32'd1);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    checkOutput("mid_rst_sel",   32'(dig_sel),    32'd0);
    checkOutput("mid_rst_dec",   32'(dec_out),    32'd0);
    checkOutput("mid_rst_err",   32'(err),        32'd0);
    checkOutput("mid_rst_done",  32'(frame_done), 32'd0);
    checkOutput("mid_rst_ready2", 32'(in_ready),  32'd0);
    rst = 1'b0;
    #1;
    checkOutput("after_rst_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    checkIdle("after_rst_idle");

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/bcd_scan_decoder.md
Name: bcd_scan_decoder

Overview:
Multi-digit BCD-to-decimal decoder with time-multiplexed scan output. It accepts a DIGITS-wide packed BCD word over a valid/ready handshake and decodes each nibble to a 10-bit one-hot decimal line. It presents one digit at a time, each held for DWELL cycles, with a matching one-hot digit select for display or indicator drivers. It adds what the single-digit combinational decoder lacks: a digit-0 output, invalid-code flagging, leading-zero blanking, frame repeat and registered outputs.

Parameters:
DIGITS, 4, number of BCD digits per word (>=2)
DWELL, 4, clock cycles each digit is held (>=1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, synchronous, active-high
in_valid  input  1  word offered
in_ready  output  1  block can accept word this cycle
in_bcd  input  4*DIGITS  packed BCD; digit i = bits [4i+3:4i], bit 4i+3 is MSB; digit 0 is least significant
blank_lz  input  1  leading-zero blanking enable, sampled on accept
repeat_en  input  1  rescan current word when no new word is accepted at frame end
dec_out  output  10  one-hot decimal of current digit; bit k = value k
dig_sel  output  DIGITS  one-hot select of current digit index
err  output  1  accepted word contained a nibble >9
frame_done  output  1  one-cycle pulse on final cycle of a frame

Behaviour:
- One clock. Reset is synchronous and active-high. All state updates occur on the rising edge of clk.
- Reset:
  - state=IDLE, dec_out=0, dig_sel=0, err=0, frame_done=0.
  - Digit index and dwell counter are 0.
  - in_ready=0 while rst=1.
  - Reset mid-frame: next cycle matches the reset state, and the latched word is discarded.
- States: IDLE, SCAN.
- in_ready (combinational) = !rst && (state==IDLE || last_cycle).
  - last_cycle = SCAN && idx==DIGITS-1 && dwell==DWELL-1.
- Accept = in_valid && in_ready at a rising edge T. On accept:
  - Latch in_bcd and blank_lz.
  - err <= OR over digits of (nibble>9).
  - idx <= 0, dwell <= 0, state <= SCAN.
- Latency: outputs for digit 0 are valid at T+1. Digit i is shown for cycles T+1+i*DWELL through T+(i+1)*DWELL.
- SCAN, every cycle:
  - dig_sel = 1<<idx.
  - dec_out = 1<<nibble[idx], except dec_out=0 when the nibble is >9 or the digit is blanked.
  - dwell increments. At DWELL-1, dwell wraps to 0 and idx increments.
- Blanking: digit i (i>=1) is blanked when latched blank_lz=1 and all nibbles j>=i are 0. Digit 0 is never blanked. dig_sel is still driven for blanked digits.
- frame_done=1 during last_cycle, otherwise 0.
- End of frame (last_cycle), in priority order:
  - New word accepted: next frame starts at the next cycle with no gap, and err is updated.
  - Otherwise, if repeat_en=1: idx <= 0, and the same word is rescanned with err unchanged.
  - Otherwise: state <= IDLE, and dec_out=0, dig_sel=0 from the next cycle.
- err holds its value until the next accept or reset.
- in_valid during mid-frame has no effect.
- in_bcd and blank_lz are ignored when no accept occurs.
- Widths:
  - idx is $clog2(DIGITS) bits.
  - dwell is max(1,$clog2(DWELL)) bits.
  - With DWELL=1 the digit advances every cycle.

Decomposition:
- Package bcd_pkg:
  - state enum {IDLE, SCAN}.
  - BCD_MAX=9.
  - DEC_W=10.
  - Blank-mask helper function (mask of digits to blank, from the word).
- Sub-module bcd_onehot_dec: combinational, 4-bit nibble -> 10-bit one-hot plus invalid flag. One instance, on the muxed current nibble.

Test Plan:
All scenarios use DIGITS=4, DWELL=2.
1. Basic frame: after reset, accept in_bcd=16'h1234, blank_lz=0, repeat_en=0.
   -> T+1..T+2: dig_sel=0001, dec_out=10'h010.
   -> then dig_sel=0010 with dec_out=10'h008, dig_sel=0100 with 10'h004, dig_sel=1000 with 10'h002.
   -> frame_done=1 at T+8; at T+9 dig_sel=0, dec_out=0, in_ready=1.
2. Blanking on: accept 16'h0070, blank_lz=1.
   -> digit0 dec_out=10'h001, digit1 10'h080, digits 2 and 3 dec_out=0 with dig_sel 0100 and 1000.
   Blanking off: same word with blank_lz=0 -> digits 2 and 3 dec_out=10'h001.
3. Invalid code: accept 16'h12A4.
   -> err=1 at T+1; digit1 dec_out=0; other digits 10'h010, 10'h004, 10'h002.
   -> a subsequent accept of 16'h0000 clears err.
4. Back-to-back: in_valid held with 16'h1111; at frame_done present 16'h2222.
   -> accepted on the last cycle; next cycle dig_sel=0001, dec_out=10'h004, with no idle cycle.
5. Repeat and mid-frame offer: repeat_en=1, word 16'h5678, in_valid pulsed mid-frame.
   -> in_ready=0 and no accept mid-frame; frame rescans identically with frame_done every 8 cycles.
6. Reset mid-frame: rst=1 while digit2 is shown.
   -> next cycle dec_out=0, dig_sel=0, err=0, frame_done=0, in_ready=0.
   -> after rst drops, in_ready=1 and IDLE.
